// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - two-requester round-robin board-to-board serial link transmitter
module serial_tx_scheduler #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic              remote_ready,
   output logic [1:0]        grant,
   output logic              done,
   output logic              busy,
   output logic              tx_ready,
   output logic              ser_clk,
   output logic              ser_data
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] BIT_END  = DIV_W'(2 * CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, WAIT_READY, SHIFT, DONE} state_t;

   state_t            state;
   logic [1:0]        rdy_sync;
   logic              rdy_s;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic              parked;
   logic              last_owner;
   logic              pick;

   assign rdy_s = rdy_sync[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_sync <= 2'b00;
      end else begin
         rdy_sync <= {rdy_sync[0], remote_ready};
      end
   end

   always_comb begin
      pick = 1'b0;
      if (req == 2'b11) begin
         pick = ~last_owner;
      end else if (req[1]) begin
         pick = 1'b1;
      end
   end

   // shreg holds the bits still to be sent after the one currently on ser_data.
   // SHIFT is entered parked at a bit boundary, so the same rdy_s gate that
   // handles mid-frame stalls also releases the first bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= 2'b00;
         done       <= 1'b0;
         busy       <= 1'b0;
         tx_ready   <= 1'b0;
         ser_clk    <= 1'b0;
         ser_data   <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         parked     <= 1'b0;
         last_owner <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (enable && (req != 2'b00)) begin
                  grant    <= pick ? 2'b10 : 2'b01;
                  shreg    <= pick ? {data1[DATA_W-2:0], 1'b0} : {data0[DATA_W-2:0], 1'b0};
                  ser_data <= pick ? data1[DATA_W-1] : data0[DATA_W-1];
                  tx_ready <= 1'b1;
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  div_cnt  <= '0;
                  state    <= WAIT_READY;
               end
            end
            WAIT_READY: begin
               if (rdy_s) begin
                  parked <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (parked) begin
                  if (rdy_s) begin
                     parked <= 1'b0;
                  end
               end else if (div_cnt == BIT_END) begin
                  ser_clk <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     tx_ready <= 1'b0;
                     ser_data <= 1'b0;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     ser_data <= shreg[DATA_W-1];
                     shreg    <= shreg << 1;
                     div_cnt  <= '0;
                     parked   <= ~rdy_s;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
                  if (div_cnt == RISE_AT) begin
                     ser_clk <= 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               done       <= 1'b0;
               busy       <= 1'b0;
               grant      <= 2'b00;
               last_owner <= grant[1];
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
